lsu_dmem_ctrl: RTL and testbench

- Load/store unit between the CPU execute stage and the data memory port.
- Takes one RV32I load or store request at a time (LB/LH/LW/LBU/LHU/SB/SH/SW), drives a word-aligned address, and returns a sign- or zero-extended load result or a store acknowledge.
- The memory port has no byte strobes, so SB/SH are done as read-modify-write of the containing word.
- Misaligned and illegal requests get an error response and never touch memory.

---
 rtl/lsu_dmem_ctrl_if.sv | 39 +++
 rtl/lsu_dmem_ctrl.sv | 175 +++++++++++++++++
 tb/tb_lsu_dmem_ctrl.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lsu_dmem_ctrl_if.sv
// Purpose: request/response and data-memory port bundle for the load/store unit.
// Latency: none, wires only.
// Backpressure: the request side uses valid/ready; the memory side has no stall.
interface lsu_dmem_ctrl_if #(
    parameter int NB_ADDR = 32,
    parameter int NB_WORD = 32
);
    logic               i_req_valid;
    logic               o_req_ready;
    logic               i_req_we;
    logic [2:0]         i_req_funct3;
    logic [NB_ADDR-1:0] i_req_addr;
    logic [NB_WORD-1:0] i_req_wdata;

    logic               o_rsp_valid;
    logic               o_rsp_err;
    logic [NB_WORD-1:0] o_rsp_rdata;

    logic [NB_ADDR-1:0] o_dmem_address;
    logic [NB_WORD-1:0] o_dmem_wr_data;
    logic               o_dmem_wr_enable;
    logic [NB_WORD-1:0] i_dmem_rd_data;

    // The load/store unit itself.
    modport slave (
        input  i_req_valid, i_req_we, i_req_funct3, i_req_addr, i_req_wdata,
        input  i_dmem_rd_data,
        output o_req_ready, o_rsp_valid, o_rsp_err, o_rsp_rdata,
        output o_dmem_address, o_dmem_wr_data, o_dmem_wr_enable
    );

    // The execute stage plus memory side that surround the unit.
    modport master (
        output i_req_valid, i_req_we, i_req_funct3, i_req_addr, i_req_wdata,
        output i_dmem_rd_data,
        input  o_req_ready, o_rsp_valid, o_rsp_err, o_rsp_rdata,
        input  o_dmem_address, o_dmem_wr_data, o_dmem_wr_enable
    );
endinterface

// File: rtl/lsu_dmem_ctrl.sv
// Purpose: RV32I load/store unit; byte/half stores done as read-modify-write of the word.
// Latency: error 1 cycle, SW 2, loads 3, SB/SH 4 cycles from acceptance to rsp_valid.
// Backpressure: one request in flight; o_req_ready is high only in IDLE.
module lsu_dmem_ctrl #(
    parameter int NB_ADDR = 32,
    parameter int NB_WORD = 32
) (
    input  logic           i_clock,
    input  logic           i_reset,
    lsu_dmem_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE,
        LD_ADDR,
        LD_DATA,
        ST_WRITE,
        RMW_ADDR,
        RMW_MERGE,
        RMW_WRITE
    } state_t;

    state_t             state_q, state_d;
    logic [1:0]         lane_q, lane_d;
    logic [2:0]         funct3_q, funct3_d;
    logic [15:0]        wdata_q, wdata_d;
    logic [NB_ADDR-1:0] dmem_addr_q, dmem_addr_d;
    logic [NB_WORD-1:0] dmem_wdata_q, dmem_wdata_d;
    logic               dmem_we_q, dmem_we_d;
    logic               rsp_vld_q, rsp_vld_d;
    logic               rsp_err_q, rsp_err_d;
    logic [NB_WORD-1:0] rsp_rdata_q, rsp_rdata_d;

    // Size/alignment legality; funct3 4/5 exist only for loads.
    function automatic logic req_legal(input logic we, input logic [2:0] f3, input logic [1:0] off);
        logic ok;
        ok = 1'b0;
        case (f3)
            3'd0:    ok = 1'b1;
            3'd1:    ok = !off[0];
            3'd2:    ok = (off == 2'b00);
            3'd4:    ok = !we;
            3'd5:    ok = !we && !off[0];
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Pick the addressed lane out of the read word and extend it; funct3[2] selects zero-extension.
    function automatic logic [NB_WORD-1:0] load_extend(input logic [NB_WORD-1:0] word,
                                                       input logic [2:0] f3, input logic [1:0] off);
        logic [7:0]         b;
        logic [15:0]        h;
        logic [NB_WORD-1:0] r;
        b = word[{off, 3'b000} +: 8];
        h = word[{off[1], 4'b0000} +: 16];
        case (f3[1:0])
            2'd0:    r = f3[2] ? {{(NB_WORD-8){1'b0}}, b}  : {{(NB_WORD-8){b[7]}}, b};
            2'd1:    r = f3[2] ? {{(NB_WORD-16){1'b0}}, h} : {{(NB_WORD-16){h[15]}}, h};
            default: r = word;
        endcase
        return r;
    endfunction

    // Replace the selected byte or halfword of the old word with the store data.
    function automatic logic [NB_WORD-1:0] store_merge(input logic [NB_WORD-1:0] word,
                                                       input logic [15:0] wd,
                                                       input logic [2:0] f3, input logic [1:0] off);
        logic [NB_WORD-1:0] m;
        m = word;
        case (f3[1:0])
            2'd0:    m[{off, 3'b000} +: 8]    = wd[7:0];
            2'd1:    m[{off[1], 4'b0000} +: 16] = wd[15:0];
            default: m = word;
        endcase
        return m;
    endfunction

    // Next-state and registered-output logic; address and write data hold unless changed here.
    always_comb begin
        state_d      = state_q;
        lane_d       = lane_q;
        funct3_d     = funct3_q;
        wdata_d      = wdata_q;
        dmem_addr_d  = dmem_addr_q;
        dmem_wdata_d = dmem_wdata_q;
        dmem_we_d    = 1'b0;
        rsp_vld_d    = 1'b0;
        rsp_err_d    = 1'b0;
        rsp_rdata_d  = '0;

        case (state_q)
            IDLE: begin
                if (bus.i_req_valid) begin
                    if (!req_legal(bus.i_req_we, bus.i_req_funct3, bus.i_req_addr[1:0])) begin
                        // Rejected requests answer next cycle and leave the memory port untouched.
                        rsp_vld_d = 1'b1;
                        rsp_err_d = 1'b1;
                    end else begin
                        lane_d      = bus.i_req_addr[1:0];
                        funct3_d    = bus.i_req_funct3;
                        wdata_d     = bus.i_req_wdata[15:0];
                        dmem_addr_d = {bus.i_req_addr[NB_ADDR-1:2], 2'b00};
                        if (!bus.i_req_we) begin
                            state_d = LD_ADDR;
                        end else if (bus.i_req_funct3[1:0] == 2'd2) begin
                            state_d      = ST_WRITE;
                            dmem_wdata_d = bus.i_req_wdata;
                            dmem_we_d    = 1'b1;
                        end else begin
                            state_d = RMW_ADDR;
                        end
                    end
                end
            end
            LD_ADDR: state_d = LD_DATA;
            LD_DATA: begin
                rsp_vld_d   = 1'b1;
                rsp_rdata_d = load_extend(bus.i_dmem_rd_data, funct3_q, lane_q);
                state_d     = IDLE;
            end
            ST_WRITE: begin
                rsp_vld_d = 1'b1;
                state_d   = IDLE;
            end
            RMW_ADDR: state_d = RMW_MERGE;
            RMW_MERGE: begin
                dmem_wdata_d = store_merge(bus.i_dmem_rd_data, wdata_q, funct3_q, lane_q);
                dmem_we_d    = 1'b1;
                state_d      = RMW_WRITE;
            end
            RMW_WRITE: begin
                rsp_vld_d = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; reset clears the write strobe immediately and drops any pending response.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state_q      <= IDLE;
            lane_q       <= '0;
            funct3_q     <= '0;
            wdata_q      <= '0;
            dmem_addr_q  <= '0;
            dmem_wdata_q <= '0;
            dmem_we_q    <= 1'b0;
            rsp_vld_q    <= 1'b0;
            rsp_err_q    <= 1'b0;
            rsp_rdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            lane_q       <= lane_d;
            funct3_q     <= funct3_d;
            wdata_q      <= wdata_d;
            dmem_addr_q  <= dmem_addr_d;
            dmem_wdata_q <= dmem_wdata_d;
            dmem_we_q    <= dmem_we_d;
            rsp_vld_q    <= rsp_vld_d;
            rsp_err_q    <= rsp_err_d;
            rsp_rdata_q  <= rsp_rdata_d;
        end
    end

    assign bus.o_req_ready      = (state_q == IDLE);
    assign bus.o_rsp_valid      = rsp_vld_q;
    assign bus.o_rsp_err        = rsp_err_q;
    assign bus.o_rsp_rdata      = rsp_rdata_q;
    assign bus.o_dmem_address   = dmem_addr_q;
    assign bus.o_dmem_wr_data   = dmem_wdata_q;
    assign bus.o_dmem_wr_enable = dmem_we_q;

endmodule

// File: tb/tb_lsu_dmem_ctrl.sv
// Purpose: directed self-checking bench for lsu_dmem_ctrl with a synchronous RAM model.
// Latency: responses are checked at their exact cycle offset from acceptance.
// Backpressure: requests are held until ready, as the upstream stage would.
module tb_lsu_dmem_ctrl;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    lsu_dmem_ctrl_if bus ();

    lsu_dmem_ctrl dut (
        .i_clock (clk),
        .i_reset (rst_n),
        .bus     (bus.slave)
    );

    // Synchronous RAM model: read data appears the cycle after the address; backdoor preload port.
    logic [31:0] mem [0:1023];
    logic        bd_we;
    logic [9:0]  bd_idx;
    logic [31:0] bd_val;

    always @(posedge clk) begin
        logic [31:0] rd;
        rd = mem[bus.o_dmem_address[11:2]];
        if (bd_we) mem[bd_idx] = bd_val;
        else if (bus.o_dmem_wr_enable) mem[bus.o_dmem_address[11:2]] = bus.o_dmem_wr_data;
        bus.i_dmem_rd_data <= rd;
    end

    int n_checks = 0;
    int n_fail   = 0;

    // Observations collected for one request over the 8 cycles after acceptance.
    int          obs_rsp_cnt, obs_rsp_cyc, obs_wr_cnt, obs_wr_cyc;
    logic        obs_err, obs_addr_moved;
    logic [31:0] obs_rdata, obs_wr_addr, obs_wr_data;

    task automatic preload(input logic [9:0] idx, input logic [31:0] val);
        bd_idx = idx;
        bd_val = val;
        bd_we  = 1'b1;
        @(posedge clk); #1;
        bd_we  = 1'b0;
    endtask

    // Present one request, wait (bounded) for acceptance, then record what happens.
    task automatic issue_req(input logic we, input logic [2:0] f3,
                             input logic [31:0] addr, input logic [31:0] wd);
        logic [31:0] addr0;
        int          waited;
        addr0          = bus.o_dmem_address;
        obs_rsp_cnt    = 0; obs_rsp_cyc = -1; obs_wr_cnt = 0; obs_wr_cyc = -1;
        obs_err        = 1'bx; obs_addr_moved = 1'b0;
        obs_rdata      = 'x; obs_wr_addr = 'x; obs_wr_data = 'x;
        bus.i_req_we     = we;
        bus.i_req_funct3 = f3;
        bus.i_req_addr   = addr;
        bus.i_req_wdata  = wd;
        bus.i_req_valid  = 1'b1;
        waited = 0;
        while (!bus.o_req_ready && waited < 20) begin
            @(posedge clk); #1;
            waited++;
        end
        @(posedge clk); #1;
        bus.i_req_valid = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            if (bus.o_rsp_valid) begin
                if (obs_rsp_cnt == 0) begin
                    obs_rsp_cyc = k;
                    obs_err     = bus.o_rsp_err;
                    obs_rdata   = bus.o_rsp_rdata;
                end
                obs_rsp_cnt++;
            end
            if (bus.o_dmem_wr_enable) begin
                if (obs_wr_cnt == 0) begin
                    obs_wr_cyc  = k;
                    obs_wr_addr = bus.o_dmem_address;
                    obs_wr_data = bus.o_dmem_wr_data;
                end
                obs_wr_cnt++;
            end
            if (bus.o_dmem_address !== addr0) obs_addr_moved = 1'b1;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (bus.o_dmem_wr_enable !== 1'b0 || bus.o_rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_async_outputs: we=%b rsp_valid=%b, required 0/0", bus.o_dmem_wr_enable, bus.o_rsp_valid);
        end
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (bus.o_req_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_ready: got %b, required 1", bus.o_req_ready);
        end
        n_checks++;
        if (bus.o_dmem_address !== 32'h0 || bus.o_dmem_wr_data !== 32'h0) begin
            n_fail++; $display("FAIL reset_dmem: addr=%h wdata=%h, required 0/0", bus.o_dmem_address, bus.o_dmem_wr_data);
        end
        n_checks++;
        if (bus.o_rsp_valid !== 1'b0 || bus.o_rsp_err !== 1'b0 || bus.o_rsp_rdata !== 32'h0) begin
            n_fail++; $display("FAIL reset_rsp: valid=%b err=%b rdata=%h, required 0/0/0",
                               bus.o_rsp_valid, bus.o_rsp_err, bus.o_rsp_rdata);
        end
    endtask

    task automatic test_loads();
        logic [2:0]  f3s  [5] = '{3'd0, 3'd4, 3'd1, 3'd5, 3'd2};
        logic [31:0] adrs [5] = '{32'h103, 32'h103, 32'h102, 32'h100, 32'h100};
        logic [31:0] exps [5] = '{32'hFFFFFF88, 32'h00000088, 32'hFFFF8899, 32'h0000AABB, 32'h8899AABB};
        preload(10'd64, 32'h8899AABB);
        for (int i = 0; i < 5; i++) begin
            issue_req(1'b0, f3s[i], adrs[i], 32'h0);
            n_checks++;
            if (obs_rsp_cyc != 3 || obs_rsp_cnt != 1) begin
                n_fail++; $display("FAIL load%0d_timing: rsp at T+%0d x%0d, required T+3 x1", i, obs_rsp_cyc, obs_rsp_cnt);
            end
            n_checks++;
            if (obs_rdata !== exps[i] || obs_err !== 1'b0) begin
                n_fail++; $display("FAIL load%0d_data: rdata=%h err=%b, required %h err=0", i, obs_rdata, obs_err, exps[i]);
            end
            n_checks++;
            if (obs_wr_cnt != 0) begin
                n_fail++; $display("FAIL load%0d_nowrite: %0d write pulses, required 0", i, obs_wr_cnt);
            end
        end
    endtask

    task automatic test_store_half();
        preload(10'd64, 32'h8899AABB);
        issue_req(1'b1, 3'd1, 32'h102, 32'h12345678);
        n_checks++;
        if (obs_wr_cnt != 1 || obs_wr_cyc != 3) begin
            n_fail++; $display("FAIL sh_wr_pulse: %0d pulses first at T+%0d, required 1 at T+3", obs_wr_cnt, obs_wr_cyc);
        end
        n_checks++;
        if (obs_wr_addr !== 32'h100 || obs_wr_data !== 32'h5678AABB) begin
            n_fail++; $display("FAIL sh_wr_word: addr=%h data=%h, required 100/5678aabb", obs_wr_addr, obs_wr_data);
        end
        n_checks++;
        if (obs_rsp_cyc != 4 || obs_rsp_cnt != 1 || obs_err !== 1'b0 || obs_rdata !== 32'h0) begin
            n_fail++; $display("FAIL sh_rsp: T+%0d x%0d err=%b rdata=%h, required T+4 x1 err=0 rdata=0",
                               obs_rsp_cyc, obs_rsp_cnt, obs_err, obs_rdata);
        end
    endtask

    task automatic test_store_byte();
        preload(10'd64, 32'h8899AABB);
        issue_req(1'b1, 3'd0, 32'h101, 32'hFFFFFFCC);
        n_checks++;
        if (mem[64] !== 32'h8899CCBB || obs_wr_cnt != 1) begin
            n_fail++; $display("FAIL sb_mem: mem=%h pulses=%0d, required 8899ccbb 1", mem[64], obs_wr_cnt);
        end
        n_checks++;
        if (obs_rsp_cyc != 4 || obs_err !== 1'b0) begin
            n_fail++; $display("FAIL sb_rsp: T+%0d err=%b, required T+4 err=0", obs_rsp_cyc, obs_err);
        end
        issue_req(1'b0, 3'd2, 32'h100, 32'h0);
        n_checks++;
        if (obs_rdata !== 32'h8899CCBB || obs_rsp_cyc != 3) begin
            n_fail++; $display("FAIL sb_readback: rdata=%h at T+%0d, required 8899ccbb at T+3", obs_rdata, obs_rsp_cyc);
        end
    endtask

    task automatic test_errors();
        logic        wes  [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        logic [2:0]  f3s  [4] = '{3'd2, 3'd1, 3'd3, 3'd4};
        logic [31:0] adrs [4] = '{32'h102, 32'h101, 32'h100, 32'h100};
        for (int i = 0; i < 4; i++) begin
            issue_req(wes[i], f3s[i], adrs[i], 32'hA5A5A5A5);
            n_checks++;
            if (obs_rsp_cyc != 1 || obs_rsp_cnt != 1 || obs_err !== 1'b1 || obs_rdata !== 32'h0) begin
                n_fail++; $display("FAIL err%0d_rsp: T+%0d x%0d err=%b rdata=%h, required T+1 x1 err=1 rdata=0",
                                   i, obs_rsp_cyc, obs_rsp_cnt, obs_err, obs_rdata);
            end
            n_checks++;
            if (obs_wr_cnt != 0 || obs_addr_moved !== 1'b0) begin
                n_fail++; $display("FAIL err%0d_quiet: pulses=%0d addr_moved=%b, required 0/0", i, obs_wr_cnt, obs_addr_moved);
            end
        end
    endtask

    task automatic test_reset_abort();
        logic saw_we, saw_rsp;
        preload(10'd64, 32'h8899AABB);
        saw_we = 1'b0; saw_rsp = 1'b0;
        bus.i_req_we = 1'b1; bus.i_req_funct3 = 3'd1; bus.i_req_addr = 32'h102;
        bus.i_req_wdata = 32'h12345678; bus.i_req_valid = 1'b1;
        @(posedge clk); #1;                 // accepted; now T+1
        bus.i_req_valid = 1'b0;
        @(posedge clk); #1;                 // T+2
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            saw_we  |= bus.o_dmem_wr_enable;
            saw_rsp |= bus.o_rsp_valid;
            @(posedge clk); #1;
        end
        @(negedge clk) rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            saw_we  |= bus.o_dmem_wr_enable;
            saw_rsp |= bus.o_rsp_valid;
        end
        n_checks++;
        if (saw_we !== 1'b0 || saw_rsp !== 1'b0) begin
            n_fail++; $display("FAIL abort_quiet: saw_we=%b saw_rsp=%b, required 0/0", saw_we, saw_rsp);
        end
        n_checks++;
        if (mem[64] !== 32'h8899AABB) begin
            n_fail++; $display("FAIL abort_mem: mem=%h, required 8899aabb", mem[64]);
        end
        n_checks++;
        if (bus.o_req_ready !== 1'b1) begin
            n_fail++; $display("FAIL abort_ready: got %b, required 1", bus.o_req_ready);
        end
    endtask

    task automatic test_back_to_back();
        bus.i_req_we = 1'b1; bus.i_req_funct3 = 3'd2; bus.i_req_addr = 32'h200;
        bus.i_req_wdata = 32'hDEADBEEF; bus.i_req_valid = 1'b1;
        @(posedge clk); #1;                 // SW accepted; T+1
        bus.i_req_we = 1'b0; bus.i_req_wdata = 32'h0;
        n_checks++;
        if (bus.o_req_ready !== 1'b0) begin
            n_fail++; $display("FAIL b2b_busy: ready=%b, required 0", bus.o_req_ready);
        end
        @(posedge clk); #1;                 // T+2: SW response, LW accepted at the next edge
        n_checks++;
        if (bus.o_rsp_valid !== 1'b1 || bus.o_rsp_err !== 1'b0 || bus.o_req_ready !== 1'b1) begin
            n_fail++; $display("FAIL b2b_sw_rsp: valid=%b err=%b ready=%b, required 1/0/1",
                               bus.o_rsp_valid, bus.o_rsp_err, bus.o_req_ready);
        end
        @(posedge clk); #1;                 // LW at L+1
        bus.i_req_valid = 1'b0;
        n_checks++;
        if (bus.o_req_ready !== 1'b0 || bus.o_rsp_valid !== 1'b0) begin
            n_fail++; $display("FAIL b2b_lw_busy: ready=%b rsp_valid=%b, required 0/0", bus.o_req_ready, bus.o_rsp_valid);
        end
        @(posedge clk); #1;                 // L+2
        @(posedge clk); #1;                 // L+3
        n_checks++;
        if (bus.o_rsp_valid !== 1'b1 || bus.o_rsp_rdata !== 32'hDEADBEEF) begin
            n_fail++; $display("FAIL b2b_lw_data: valid=%b rdata=%h, required 1 deadbeef", bus.o_rsp_valid, bus.o_rsp_rdata);
        end
    endtask

    initial begin
        bus.i_req_valid  = 1'b0;
        bus.i_req_we     = 1'b0;
        bus.i_req_funct3 = 3'd0;
        bus.i_req_addr   = 32'h0;
        bus.i_req_wdata  = 32'h0;
        bd_we = 1'b0; bd_idx = '0; bd_val = '0;
        test_reset();
        test_loads();
        test_store_half();
        test_store_byte();
        test_errors();
        test_reset_abort();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1);
    end

endmodule
